// File: rtl/tt_capture_seq.sv
// tt_capture_seq: sequential truth-table capture for a 4-input AIG block.
// Walks x0..x3 through all 16 minterms and samples y0 after a settle delay.
//
// Parameters:
//   SETTLE_CYCLES  cycles x0..x3 are held before y0 is sampled (0..255)
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start        begin a capture (accepted only when idle)
//   abort        cancel an in-progress capture (drive/sample phases only)
//   busy         high while driving, sampling or holding a finished table
//   x0..x3       registered minterm bits to the AIG block inputs
//   y0           AIG block output (combinational from x0..x3)
//   tt_out       captured table, bit m = y0 for minterm m
//   tt_valid     tt_out holds a complete table
//   tt_ready     downstream accepts tt_out
//   expected_tt  reference table (only with TT_CHECK_EN)
//   match        registered tt_out == expected_tt (only with TT_CHECK_EN)
//
// Optional feature macro: TT_CHECK_EN (reference compare of the final table).

module tt_capture_seq #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        x0,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    input  logic        y0,
    output logic [15:0] tt_out,
    output logic        tt_valid,
    input  logic        tt_ready,
    input  logic [15:0] expected_tt,
    output logic        match
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    // With no settle time the drive phase is skipped entirely, so every
    // minterm is loaded straight into the sample phase.
    localparam state_t LOAD_ST = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;

    state_t      state;
    logic [3:0]  m;
    logic [7:0]  cnt;
    logic [3:0]  x;
    logic [7:0]  cnt_inc;
    logic [3:0]  m_inc;
    logic [15:0] tt_next;
    logic        last_sample;

    assign x0 = x[0];
    assign x1 = x[1];
    assign x2 = x[2];
    assign x3 = x[3];

    assign cnt_inc = cnt + 8'd1;
    assign m_inc   = m + 4'd1;

    // A sample edge that completes the table (and is not cancelled).
    assign last_sample = (state == SAMPLE) && !abort && (m == 4'd15);

    // Table as it will look after the current sample edge; each bit is
    // written exactly once per capture since m only moves forward.
    always_comb begin
        tt_next    = tt_out;
        tt_next[m] = y0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            m        <= 4'd0;
            cnt      <= 8'd0;
            x        <= 4'd0;
            busy     <= 1'b0;
            tt_out   <= 16'h0000;
            tt_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // start wins over a simultaneous abort here
                    if (start) begin
                        state  <= LOAD_ST;
                        m      <= 4'd0;
                        cnt    <= 8'd0;
                        x      <= 4'd0;
                        busy   <= 1'b1;
                        tt_out <= 16'h0000;
                    end
                end

                DRIVE: begin
                    if (abort) begin
                        state <= IDLE;
                        m     <= 4'd0;
                        cnt   <= 8'd0;
                        x     <= 4'd0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == SETTLE) begin
                            state <= SAMPLE;
                        end
                    end
                end

                SAMPLE: begin
                    if (abort) begin
                        // partial table is kept but never validated
                        state <= IDLE;
                        m     <= 4'd0;
                        cnt   <= 8'd0;
                        x     <= 4'd0;
                        busy  <= 1'b0;
                    end else begin
                        tt_out <= tt_next;
                        cnt    <= 8'd0;
                        if (m == 4'd15) begin
                            state    <= DONE;
                            x        <= 4'd0;
                            tt_valid <= 1'b1;
                        end else begin
                            state <= LOAD_ST;
                            m     <= m_inc;
                            x     <= m_inc;
                        end
                    end
                end

                DONE: begin
                    // abort and start are ignored until the table is taken
                    if (tt_ready) begin
                        state    <= IDLE;
                        m        <= 4'd0;
                        busy     <= 1'b0;
                        tt_valid <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TT_CHECK_EN
    // Compare is taken on the edge that enters DONE, using the table
    // including the final bit being written on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            match <= 1'b0;
        end else if (last_sample) begin
            match <= (tt_next == expected_tt);
        end else if (state == DONE && tt_ready) begin
            match <= 1'b0;
        end
    end
`else
    logic unused_check;

    assign match        = 1'b0;
    assign unused_check = ^{expected_tt, last_sample};
`endif

endmodule

// File: tb/tb_tt_capture_seq.sv
// tb_tt_capture_seq: directed bench for tt_capture_seq.
// Parity DUT with SETTLE_CYCLES=1, AND DUT with SETTLE_CYCLES=0.

module tb_tt_capture_seq;

    logic        clk;
    logic        rst;

    logic        par_start, par_abort, par_ready;
    logic        par_busy, par_valid, par_match, par_y0;
    logic        par_x0, par_x1, par_x2, par_x3;
    logic [15:0] par_tt, par_exp;

    logic        and_start, and_abort, and_ready;
    logic        and_busy, and_valid, and_match, and_y0;
    logic        and_x0, and_x1, and_x2, and_x3;
    logic [15:0] and_tt, and_exp;

    int          n_checks;
    int          n_pass;
    logic        early;
    logic        exp_match_par;

    assign par_y0 = par_x0 ^ par_x1 ^ par_x2 ^ par_x3;
    assign and_y0 = and_x0 & and_x1 & and_x2 & and_x3;

    tt_capture_seq #(.SETTLE_CYCLES(1)) u_par (
        .clk         (clk),
        .rst         (rst),
        .start       (par_start),
        .abort       (par_abort),
        .busy        (par_busy),
        .x0          (par_x0),
        .x1          (par_x1),
        .x2          (par_x2),
        .x3          (par_x3),
        .y0          (par_y0),
        .tt_out      (par_tt),
        .tt_valid    (par_valid),
        .tt_ready    (par_ready),
        .expected_tt (par_exp),
        .match       (par_match)
    );

    tt_capture_seq #(.SETTLE_CYCLES(0)) u_and (
        .clk         (clk),
        .rst         (rst),
        .start       (and_start),
        .abort       (and_abort),
        .busy        (and_busy),
        .x0          (and_x0),
        .x1          (and_x1),
        .x2          (and_x2),
        .x3          (and_x3),
        .y0          (and_y0),
        .tt_out      (and_tt),
        .tt_valid    (and_valid),
        .tt_ready    (and_ready),
        .expected_tt (and_exp),
        .match       (and_match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] px();
        return {28'd0, par_x3, par_x2, par_x1, par_x0};
    endfunction

    function automatic logic [31:0] ax();
        return {28'd0, and_x3, and_x2, and_x1, and_x0};
    endfunction

    initial begin
        n_checks  = 0;
        n_pass    = 0;
`ifdef TT_CHECK_EN
        exp_match_par = 1'b1;
`else
        exp_match_par = 1'b0;
`endif
        rst       = 1'b1;
        par_start = 1'b0; par_abort = 1'b0; par_ready = 1'b0;
        and_start = 1'b0; and_abort = 1'b0; and_ready = 1'b0;
        par_exp   = 16'h6996;
        and_exp   = 16'h0000;
        tick();
        tick();

        // reset state
        check("rst_busy",  {31'd0, par_busy},  0);
        check("rst_x",     px(),               0);
        check("rst_tt",    {16'd0, par_tt},    0);
        check("rst_valid", {31'd0, par_valid}, 0);
        check("rst_match", {31'd0, par_match}, 0);
        check("rst_and",   {11'd0, and_busy, and_valid, and_match,
                            ax()[3:0], and_tt}, 0);
        rst = 1'b0;
        tick();

        // parity, settle 1: valid exactly 32 edges after accept
        par_ready = 1'b1;
        par_start = 1'b1;
        tick();
        par_start = 1'b0;
        check("par_busy_run", {31'd0, par_busy}, 1);
        early = 1'b0;
        for (int i = 1; i < 32; i++) begin
            tick();
            early |= par_valid;
        end
        check("par_early", {31'd0, early}, 0);
        tick();
        check("par_valid", {31'd0, par_valid}, 1);
        check("par_tt",    {16'd0, par_tt},    32'h6996);
        check("par_match", {31'd0, par_match}, {31'd0, exp_match_par});
        check("par_x_done", px(), 0);
        tick();
        check("par_idle_busy",  {31'd0, par_busy},  0);
        check("par_idle_valid", {31'd0, par_valid}, 0);
        check("par_tt_keep",    {16'd0, par_tt},    32'h6996);
        check("par_match_clr",  {31'd0, par_match}, 0);

        // AND, settle 0: valid after 16 edges, table 8000
        and_ready = 1'b1;
        and_start = 1'b1;
        tick();
        and_start = 1'b0;
        early = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            early |= and_valid;
        end
        check("and_early", {31'd0, early}, 0);
        tick();
        check("and_valid", {31'd0, and_valid}, 1);
        check("and_tt",    {16'd0, and_tt},    32'h8000);
        check("and_match", {31'd0, and_match}, 0);
        tick();
        check("and_idle", {31'd0, and_busy}, 0);

        // backpressure
        par_ready = 1'b0;
        par_start = 1'b1;
        tick();
        par_start = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        check("bp_valid0", {31'd0, par_valid}, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", {31'd0, par_valid}, 1);
            check("bp_tt",    {16'd0, par_tt},    32'h6996);
            check("bp_busy",  {31'd0, par_busy},  1);
            check("bp_x",     px(),               0);
        end
        par_ready = 1'b1;
        tick();
        check("bp_rel_busy",  {31'd0, par_busy},  0);
        check("bp_rel_valid", {31'd0, par_valid}, 0);

        // abort during sample of m=7
        par_start = 1'b1;
        tick();
        par_start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("ab_x7",   px(),              7);
        check("ab_busy", {31'd0, par_busy}, 1);
        par_abort = 1'b1;
        tick();
        par_abort = 1'b0;
        check("ab_idle",  {31'd0, par_busy},  0);
        check("ab_x0",    px(),               0);
        check("ab_valid", {31'd0, par_valid}, 0);
        check("ab_part",  {16'd0, par_tt},    32'h0016);
        early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            early |= par_valid;
        end
        check("ab_never_valid", {31'd0, early}, 0);
        par_start = 1'b1;
        tick();
        par_start = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        check("ab_re_valid", {31'd0, par_valid}, 1);
        check("ab_re_tt",    {16'd0, par_tt},    32'h6996);
        tick();

        // start spam while busy and during the handshake
        par_ready = 1'b0;
        par_start = 1'b1;
        tick();
        early = 1'b0;
        for (int i = 1; i < 32; i++) begin
            tick();
            early |= par_valid;
        end
        check("sp_early", {31'd0, early}, 0);
        tick();
        check("sp_valid", {31'd0, par_valid}, 1);
        for (int i = 0; i < 3; i++) tick();
        check("sp_hold", {31'd0, par_valid}, 1);
        check("sp_tt",   {16'd0, par_tt},    32'h6996);
        par_ready = 1'b1;
        tick();
        par_start = 1'b0;
        check("sp_hs_busy",  {31'd0, par_busy},  0);
        check("sp_hs_valid", {31'd0, par_valid}, 0);
        tick();
        check("sp_no_restart", {31'd0, par_busy}, 0);

        // reset while driving m=9
        par_start = 1'b1;
        tick();
        par_start = 1'b0;
        for (int i = 0; i < 18; i++) tick();
        check("rs_x9",   px(),              9);
        check("rs_busy", {31'd0, par_busy}, 1);
        check("rs_part", {16'd0, par_tt},   32'h0196);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_tt",    {16'd0, par_tt},    0);
        check("rs_busy0", {31'd0, par_busy},  0);
        check("rs_x",     px(),               0);
        check("rs_match", {31'd0, par_match}, 0);
        check("rs_valid", {31'd0, par_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tt_capture_seq.md
Name: tt_capture_seq

Overview:
- Sequential truth-table capture stage for the 4-input single-output AIG blocks in this codebase.
- Drives the block's x0..x3 inputs through all 16 minterms and samples its y0 output after a programmable settle time.
- Assembles the 16-bit truth table and hands it downstream over a valid/ready handshake.
- Sits directly around an AIG block: feeds its inputs and consumes its output, for on-chip self-check of synthesized functions.

Parameters:
SETTLE_CYCLES, 1, cycles x0..x3 are held before y0 is sampled for each minterm; legal range 0..255

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a capture; honoured only in IDLE
abort  input  1  synchronous cancel of an in-progress capture
busy  output  1  high in DRIVE, SAMPLE and DONE
x0  output  1  minterm bit 0, to the AIG block's x0
x1  output  1  minterm bit 1, to the AIG block's x1
x2  output  1  minterm bit 2, to the AIG block's x2
x3  output  1  minterm bit 3, to the AIG block's x3
y0  input  1  AIG block output, combinational from x0..x3
tt_out  output  16  captured truth table; bit m = y0 for minterm m
tt_valid  output  1  tt_out holds a complete table
tt_ready  input  1  downstream accepts tt_out
expected_tt  input  16  reference table (used only with TT_CHECK_EN)
match  output  1  tt_out == expected_tt (only with TT_CHECK_EN)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state IDLE; busy=0, x0..x3=0, tt_out=16'h0000, tt_valid=0, match=0; minterm index m=0; settle counter=0.
- Minterm mapping: x0=m[0], x1=m[1], x2=m[2], x3=m[3]. x0..x3 are registered outputs.
- States:
  - IDLE: x=0. start=1 at an edge -> DRIVE with m=0, counter=0, tt_out cleared to 0.
  - DRIVE: x=m; counter increments each cycle. When counter reaches SETTLE_CYCLES -> SAMPLE. With SETTLE_CYCLES=0, DRIVE is skipped and the next state is SAMPLE directly.
  - SAMPLE: one cycle; x=m. At the ending edge, tt_out[m] <= y0. If m==15 -> DONE; else m <= m+1, counter=0, next DRIVE (or SAMPLE if SETTLE_CYCLES=0).
  - DONE: tt_valid=1; x=0; tt_out stable. tt_valid && tt_ready at an edge -> IDLE with tt_valid=0. tt_out retains its value until the next start.
- Timing: each minterm takes SETTLE_CYCLES+1 cycles. tt_valid rises after the edge that is 16*(SETTLE_CYCLES+1) edges after the edge accepting start. With SETTLE_CYCLES=1 this is 32 edges.
- start outside IDLE is ignored. start in the same cycle as a DONE handshake is ignored; a new start is accepted only in IDLE.
- abort=1 in DRIVE or SAMPLE -> IDLE next edge:
  - x=0, m=0, tt_valid stays 0, partial tt_out is kept but never validated.
  - abort in DONE is ignored; the table is complete and must be consumed.
  - abort in IDLE has no effect.
- abort and start high together in IDLE: start wins.
- rst mid-operation: identical to reset values above, regardless of state; overrides abort and start.
- m is 4-bit and never wraps past 15 within a capture.
- tt_out bit writes are write-once per capture.

Optional Feature:
- Macro TT_CHECK_EN.
- Defined: match is a register updated on the DONE entry edge to (final tt_out == expected_tt). It is held through DONE and cleared to 0 on the handshake and on rst. expected_tt is sampled only on that edge.
- Undefined: match tied 0, expected_tt unused; all other behaviour identical.

Test Plan:
- 4-input parity DUT (y0 = x0^x1^x2^x3), SETTLE_CYCLES=1, tt_ready=1 -> tt_valid after exactly 32 edges, tt_out=16'h6996; with TT_CHECK_EN and expected_tt=16'h6996, match=1.
- 4-input AND DUT, SETTLE_CYCLES=0, expected_tt=16'h0000 -> tt_out=16'h8000 after 16 edges; match=0 with TT_CHECK_EN.
- Backpressure: parity DUT, tt_ready=0 for 10 cycles after tt_valid -> tt_valid and tt_out=16'h6996 held stable, busy=1, x=0; tt_ready=1 -> IDLE next edge, busy=0.
- abort asserted during SAMPLE of m=7 -> next edge IDLE, x=0, tt_valid never rises; a fresh start then yields a correct full table.
- start pulsed repeatedly while busy and during the DONE handshake -> exactly one capture completes, no second start accepted until IDLE.
- rst asserted in DRIVE at m=9 -> next edge all outputs at reset values (tt_out=0, busy=0, x=0, match=0).
